// File: rtl/mem_bus_pkg.sv
// Shared types for the tagged memory bus scheduler: bus command codes,
// tag type, tag-table entry and issue-slot states.
package mem_bus_pkg;

   typedef logic [1:0] bus_cmd_t;

   localparam bus_cmd_t BUS_NONE  = 2'b00;
   localparam bus_cmd_t BUS_LOAD  = 2'b01;
   localparam bus_cmd_t BUS_STORE = 2'b10;

   localparam int NUM_TAGS = 15;

   typedef logic [3:0] tag_t;

   typedef struct packed {
      logic        valid;
      logic        is_load;
      logic [63:0] addr;
   } tag_entry_t;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'b00,
      SLOT_LOAD  = 2'b01,
      SLOT_STORE = 2'b10
   } slot_state_t;

   function automatic bus_cmd_t slot_cmd(input slot_state_t s);
      case (s)
         SLOT_LOAD:  return BUS_LOAD;
         SLOT_STORE: return BUS_STORE;
         default:    return BUS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_bus_scheduler_if.sv
// Requester and memory-side signals of the scheduler; master is the scheduler,
// slave is the requesters plus memory.
interface mem_bus_scheduler_if;
   import mem_bus_pkg::*;

   logic        ld_req_valid;
   logic        ld_req_ready;
   logic [63:0] ld_req_addr;
   logic        st_req_valid;
   logic        st_req_ready;
   logic [63:0] st_req_addr;
   logic [63:0] st_req_data;
   logic        ld_rsp_valid;
   logic [63:0] ld_rsp_addr;
   logic [63:0] ld_rsp_data;
   logic        st_done;
   tag_t        mem2proc_response;
   logic [63:0] mem2proc_data;
   tag_t        mem2proc_tag;
   bus_cmd_t    proc2mem_command;
   logic [63:0] proc2mem_address;
   logic [63:0] proc2mem_data;

   modport master (
      input  ld_req_valid, ld_req_addr, st_req_valid, st_req_addr, st_req_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output ld_req_ready, st_req_ready, ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      output st_done, proc2mem_command, proc2mem_address, proc2mem_data
   );

   modport slave (
      output ld_req_valid, ld_req_addr, st_req_valid, st_req_addr, st_req_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  ld_req_ready, st_req_ready, ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      input  st_done, proc2mem_command, proc2mem_address, proc2mem_data
   );

endinterface

// File: rtl/mem_tag_table.sv
// Outstanding-transaction table indexed by memory tag (1..15); retire is applied before
// allocate so a tag may be reused in its completion cycle. Entries update on the next edge.
module mem_tag_table
   import mem_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        alloc_en,
   input  tag_t        alloc_tag,
   input  logic        alloc_is_load,
   input  logic [63:0] alloc_addr,
   input  tag_t        retire_tag,
   output tag_entry_t  retire_entry,
   output logic [4:0]  count,
   output logic [4:0]  count_next,
   output logic        err
);

   tag_entry_t entries [NUM_TAGS+1];
   tag_entry_t hit_entry;
   logic       retire_en;
   logic       retire_hit;
   logic       retire_miss;
   logic       alloc_clash;

   // retire_entry.valid means "this completion matched a live entry".
   always_comb begin
      hit_entry    = entries[retire_tag];
      retire_en    = (retire_tag != '0);
      retire_hit   = retire_en && hit_entry.valid;
      retire_miss  = retire_en && !hit_entry.valid;
      retire_entry = hit_entry;
      retire_entry.valid = retire_hit;
      alloc_clash  = alloc_en && entries[alloc_tag].valid &&
                     !(retire_hit && (retire_tag == alloc_tag));
      count_next   = count - 5'(retire_hit) + 5'(alloc_en && !alloc_clash);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i <= NUM_TAGS; i++) begin
            entries[i] <= '0;
         end
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (retire_en) begin
            entries[retire_tag].valid <= 1'b0;
         end
         if (alloc_en) begin
            entries[alloc_tag] <= '{valid: 1'b1, is_load: alloc_is_load, addr: alloc_addr};
         end
         count <= count_next;
         err   <= err | retire_miss | alloc_clash;
      end
   end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Arbitrates load/store requesters onto one tagged memory bus through a registered issue slot;
// requests hit the bus 1 cycle after handshake, completions return 1 cycle after the tag.
module mem_bus_scheduler
   import mem_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 3
) (
   input  logic                clock,
   input  logic                reset,
   mem_bus_scheduler_if.master bus,
   output logic [4:0]          outstanding_count,
   output logic                tag_err
);

   localparam logic [5:0] MAX_LIVE   = 6'(MAX_OUTSTANDING);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   slot_state_t state;
   slot_state_t state_next;
   logic [63:0] slot_addr;
   logic [63:0] slot_data;
   logic [7:0]  starve_cnt;
   logic        slot_valid;
   logic        accept;
   logic        can_load;
   logic        ld_grant;
   logic        st_grant;
   tag_entry_t  retire_entry;
   logic [4:0]  count_next;
   logic        ld_rsp_valid_q;
   logic [63:0] ld_rsp_addr_q;
   logic [63:0] ld_rsp_data_q;
   logic        st_done_q;

   assign slot_valid = (state != SLOT_EMPTY);
   assign accept     = slot_valid && (bus.mem2proc_response != '0);

   mem_tag_table u_tag_table (
      .clock         (clock),
      .reset         (reset),
      .alloc_en      (accept),
      .alloc_tag     (bus.mem2proc_response),
      .alloc_is_load (state == SLOT_LOAD),
      .alloc_addr    (slot_addr),
      .retire_tag    (bus.mem2proc_tag),
      .retire_entry  (retire_entry),
      .count         (outstanding_count),
      .count_next    (count_next),
      .err           (tag_err)
   );

   // The slot counts toward the in-flight limit, hence the +1.
   assign can_load = (!slot_valid || accept) && (({1'b0, count_next} + 6'd1) <= MAX_LIVE);

   always_comb begin
      state_next = state;
      ld_grant   = 1'b0;
      st_grant   = 1'b0;
      if (can_load) begin
         if (bus.st_req_valid && !(bus.ld_req_valid && (starve_cnt == STARVE_MAX))) begin
            st_grant = 1'b1;
         end else if (bus.ld_req_valid) begin
            ld_grant = 1'b1;
         end
      end
      if (st_grant) begin
         state_next = SLOT_STORE;
      end else if (ld_grant) begin
         state_next = SLOT_LOAD;
      end else if (accept) begin
         state_next = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_addr  <= '0;
         slot_data  <= '0;
         starve_cnt <= '0;
      end else begin
         if (st_grant) begin
            slot_addr <= bus.st_req_addr;
            slot_data <= bus.st_req_data;
         end else if (ld_grant) begin
            slot_addr <= bus.ld_req_addr;
            slot_data <= '0;
         end else if (accept) begin
            slot_addr <= '0;
            slot_data <= '0;
         end
         // Counts stores that jumped a waiting load; any gap in load demand forgives it.
         if (!bus.ld_req_valid || ld_grant) begin
            starve_cnt <= '0;
         end else if (st_grant) begin
            starve_cnt <= starve_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ld_rsp_valid_q <= 1'b0;
         ld_rsp_addr_q  <= '0;
         ld_rsp_data_q  <= '0;
         st_done_q      <= 1'b0;
      end else begin
         ld_rsp_valid_q <= retire_entry.valid && retire_entry.is_load;
         ld_rsp_addr_q  <= (retire_entry.valid && retire_entry.is_load) ? retire_entry.addr : '0;
         ld_rsp_data_q  <= (retire_entry.valid && retire_entry.is_load) ? bus.mem2proc_data : '0;
         st_done_q      <= retire_entry.valid && !retire_entry.is_load;
      end
   end

   assign bus.ld_req_ready     = ld_grant;
   assign bus.st_req_ready     = st_grant;
   assign bus.proc2mem_command = slot_cmd(state);
   assign bus.proc2mem_address = slot_addr;
   assign bus.proc2mem_data    = slot_data;
   assign bus.ld_rsp_valid     = ld_rsp_valid_q;
   assign bus.ld_rsp_addr      = ld_rsp_addr_q;
   assign bus.ld_rsp_data      = ld_rsp_data_q;
   assign bus.st_done          = st_done_q;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the scheduler.
module tb_mem_bus_scheduler;
   import mem_bus_pkg::*;

   localparam int MAXO = 4;
   localparam int SLIM = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] outstanding_count;
   logic       tag_err;
   int         checks = 0;
   int         fails  = 0;

   mem_bus_scheduler_if bus();

   mem_bus_scheduler #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
      .clock             (clock),
      .reset             (reset),
      .bus               (bus),
      .outstanding_count (outstanding_count),
      .tag_err           (tag_err)
   );

   always #5 clock = ~clock;

   // Model: pending command, per-tag table, starvation run, pending completion pulses.
   bit          m_slot_v, m_slot_ld;
   logic [63:0] m_slot_addr, m_slot_data;
   bit          m_tv [16];
   bit          m_tl [16];
   logic [63:0] m_ta [16];
   int          m_starve;
   bit          m_err, m_ldrsp, m_stdone;
   logic [63:0] m_ldrsp_addr, m_ldrsp_data;
   bit          e_ld_rdy, e_st_rdy;

   function automatic int live();
      int n = 0;
      for (int t = 1; t < 16; t++) n += int'(m_tv[t]);
      return n;
   endfunction

   function automatic logic [1:0] exp_cmd();
      if (!m_slot_v) return 2'b00;
      return m_slot_ld ? 2'b01 : 2'b10;
   endfunction

   task automatic model_eval();
      bit tv [16];
      bit acc, can;
      int after = 0;
      acc = m_slot_v && (bus.mem2proc_response != 0);
      tv = m_tv;
      if (bus.mem2proc_tag != 0) tv[bus.mem2proc_tag] = 0;
      if (acc) tv[bus.mem2proc_response] = 1;
      for (int t = 1; t < 16; t++) after += int'(tv[t]);
      can = (!m_slot_v || acc) && (after + 1 <= MAXO);
      e_st_rdy = can && bus.st_req_valid && !(bus.ld_req_valid && m_starve == SLIM);
      e_ld_rdy = can && bus.ld_req_valid && !e_st_rdy;
   endtask

   task automatic model_commit();
      bit acc;
      if (reset) begin
         m_slot_v = 0; m_slot_ld = 0; m_slot_addr = 0; m_slot_data = 0;
         for (int t = 0; t < 16; t++) begin m_tv[t] = 0; m_tl[t] = 0; m_ta[t] = 0; end
         m_starve = 0; m_err = 0; m_ldrsp = 0; m_stdone = 0; m_ldrsp_addr = 0; m_ldrsp_data = 0;
         return;
      end
      acc = m_slot_v && (bus.mem2proc_response != 0);
      m_ldrsp = 0; m_stdone = 0;
      if (bus.mem2proc_tag != 0) begin
         if (m_tv[bus.mem2proc_tag]) begin
            if (m_tl[bus.mem2proc_tag]) begin
               m_ldrsp = 1; m_ldrsp_addr = m_ta[bus.mem2proc_tag]; m_ldrsp_data = bus.mem2proc_data;
            end else m_stdone = 1;
            m_tv[bus.mem2proc_tag] = 0;
         end else m_err = 1;
      end
      if (acc) begin
         if (m_tv[bus.mem2proc_response]) m_err = 1;
         m_tv[bus.mem2proc_response] = 1;
         m_tl[bus.mem2proc_response] = m_slot_ld;
         m_ta[bus.mem2proc_response] = m_slot_addr;
      end
      if (!bus.ld_req_valid || e_ld_rdy) m_starve = 0;
      else if (e_st_rdy) m_starve++;
      if (e_st_rdy) begin
         m_slot_v = 1; m_slot_ld = 0; m_slot_addr = bus.st_req_addr; m_slot_data = bus.st_req_data;
      end else if (e_ld_rdy) begin
         m_slot_v = 1; m_slot_ld = 1; m_slot_addr = bus.ld_req_addr; m_slot_data = 0;
      end else if (acc) begin
         m_slot_v = 0; m_slot_addr = 0; m_slot_data = 0;
      end
   endtask

   // Drive one cycle's inputs just after the edge, then move to the sampling point.
   task automatic set_in(input logic ldv, input logic [63:0] lda, input logic stv,
                         input logic [63:0] sta, input logic [63:0] std,
                         input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] mdat);
      bus.ld_req_valid = ldv; bus.ld_req_addr = lda;
      bus.st_req_valid = stv; bus.st_req_addr = sta; bus.st_req_data = std;
      bus.mem2proc_response = resp; bus.mem2proc_tag = tag; bus.mem2proc_data = mdat;
      model_eval();
      #1;
   endtask

   task automatic advance();
      model_eval();
      model_commit();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      advance();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.proc2mem_command !== BUS_NONE) begin fails++; $display("FAIL reset_cmd: got %0d want 0", bus.proc2mem_command); end
      checks++; if (bus.proc2mem_address !== 64'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.proc2mem_address); end
      checks++; if (bus.ld_rsp_valid !== 1'b0 || bus.st_done !== 1'b0) begin fails++; $display("FAIL reset_rsp: ld %b st %b want 0 0", bus.ld_rsp_valid, bus.st_done); end
      checks++; if (outstanding_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", outstanding_count); end
      checks++; if (tag_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", tag_err); end
      advance();
   endtask

   task automatic test_single_load();
      do_reset();
      set_in(1, 64'h40, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.ld_req_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", bus.ld_req_ready); end
      advance();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, (i == 2) ? 4'd5 : 4'd0, 0, 0);
         checks++; if (bus.proc2mem_command !== BUS_LOAD || bus.proc2mem_address !== 64'h40 || bus.proc2mem_data !== 64'd0)
            begin fails++; $display("FAIL single_hold%0d: cmd %0d addr %h data %h want 1 40 0", i, bus.proc2mem_command, bus.proc2mem_address, bus.proc2mem_data); end
         advance();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.proc2mem_command !== BUS_NONE || outstanding_count !== 5'd1)
         begin fails++; $display("FAIL single_issued: cmd %0d count %0d want 0 1", bus.proc2mem_command, outstanding_count); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 4'd5, 64'hDEADBEEF_00000001);
      checks++; if (bus.ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early: ld_rsp_valid %b want 0", bus.ld_rsp_valid); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_addr !== 64'h40 || bus.ld_rsp_data !== 64'hDEADBEEF_00000001)
         begin fails++; $display("FAIL single_rsp: v %b addr %h data %h want 1 40 deadbeef00000001", bus.ld_rsp_valid, bus.ld_rsp_addr, bus.ld_rsp_data); end
      checks++; if (outstanding_count !== 5'd0) begin fails++; $display("FAIL single_count: got %0d want 0", outstanding_count); end
      advance();
   endtask

   task automatic test_starvation();
      logic [3:0] pend = 0;
      logic [3:0] r;
      bit want_ld;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         r = m_slot_v ? ((pend == 4'd1) ? 4'd2 : 4'd1) : 4'd0;
         set_in(1, 64'h1000 + 64'(i), 1, 64'h2000 + 64'(i), 64'(i), r, pend, 64'(i));
         want_ld = (i % 4 == 3);
         checks++; if (bus.ld_req_ready !== want_ld || bus.st_req_ready !== !want_ld)
            begin fails++; $display("FAIL starve_grant%0d: ld %b st %b want ld %b st %b", i, bus.ld_req_ready, bus.st_req_ready, want_ld, !want_ld); end
         advance();
         pend = r;
      end
   endtask

   task automatic test_max_outstanding();
      logic [3:0] t = 4'd1;
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         r = m_slot_v ? t : 4'd0;
         set_in(1, 64'h1000 + 64'(i * 8), 0, 0, 0, r, 0, 0);
         checks++; if (bus.ld_req_ready !== (i < 4)) begin fails++; $display("FAIL max_ready%0d: got %b want %b", i, bus.ld_req_ready, i < 4); end
         advance();
         if (r != 0) t++;
      end
      set_in(1, 64'h2000, 0, 0, 0, 0, 0, 0);
      checks++; if (outstanding_count !== 5'd4 || bus.ld_req_ready !== 1'b0)
         begin fails++; $display("FAIL max_full: count %0d ready %b want 4 0", outstanding_count, bus.ld_req_ready); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 4'd2, 64'h55);
      advance();
      set_in(1, 64'h3000, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.ld_req_ready !== 1'b1 || outstanding_count !== 5'd3)
         begin fails++; $display("FAIL max_reopen: ready %b count %0d want 1 3", bus.ld_req_ready, outstanding_count); end
      checks++; if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_addr !== 64'h1008 || bus.ld_rsp_data !== 64'h55)
         begin fails++; $display("FAIL max_rsp: v %b addr %h data %h want 1 1008 55", bus.ld_rsp_valid, bus.ld_rsp_addr, bus.ld_rsp_data); end
      advance();
   endtask

   task automatic test_tag_reuse();
      do_reset();
      set_in(0, 0, 1, 64'h100, 64'hA, 0, 0, 0);
      advance();
      set_in(0, 0, 0, 0, 0, 4'd7, 0, 0);
      advance();
      set_in(0, 0, 1, 64'h200, 64'hB, 0, 0, 0);
      advance();
      set_in(0, 0, 0, 0, 0, 4'd7, 4'd7, 0);
      checks++; if (bus.proc2mem_command !== BUS_STORE || bus.proc2mem_data !== 64'hB || outstanding_count !== 5'd1)
         begin fails++; $display("FAIL reuse_pre: cmd %0d data %h count %0d want 2 b 1", bus.proc2mem_command, bus.proc2mem_data, outstanding_count); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (outstanding_count !== 5'd1 || tag_err !== 1'b0 || bus.st_done !== 1'b1)
         begin fails++; $display("FAIL reuse_same: count %0d err %b st_done %b want 1 0 1", outstanding_count, tag_err, bus.st_done); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 4'd7, 0);
      advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.st_done !== 1'b1 || bus.ld_rsp_valid !== 1'b0 || outstanding_count !== 5'd0 || tag_err !== 1'b0)
         begin fails++; $display("FAIL reuse_done: st %b ld %b count %0d err %b want 1 0 0 0", bus.st_done, bus.ld_rsp_valid, outstanding_count, tag_err); end
      advance();
   endtask

   task automatic test_unknown_tag();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 4'd9, 64'h99);
      checks++; if (tag_err !== 1'b0) begin fails++; $display("FAIL unk_pre: err %b want 0", tag_err); end
      advance();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (tag_err !== 1'b1 || bus.ld_rsp_valid !== 1'b0 || bus.st_done !== 1'b0)
            begin fails++; $display("FAIL unk_sticky%0d: err %b ld %b st %b want 1 0 0", i, tag_err, bus.ld_rsp_valid, bus.st_done); end
         advance();
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 64'h500 + 64'(i), 0, 0, 0, 4'(i), 0, 0);
         advance();
      end
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (outstanding_count !== 5'd2 || bus.proc2mem_command !== BUS_LOAD)
         begin fails++; $display("FAIL midrst_pre: count %0d cmd %0d want 2 1", outstanding_count, bus.proc2mem_command); end
      advance();
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.proc2mem_command !== BUS_NONE || outstanding_count !== 5'd0 || tag_err !== 1'b0)
         begin fails++; $display("FAIL midrst_clear: cmd %0d count %0d err %b want 0 0 0", bus.proc2mem_command, outstanding_count, tag_err); end
      advance();
      set_in(0, 0, 0, 0, 0, 0, 4'd1, 64'h7);
      advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (tag_err !== 1'b1 || bus.ld_rsp_valid !== 1'b0)
         begin fails++; $display("FAIL midrst_stale: err %b ld %b want 1 0", tag_err, bus.ld_rsp_valid); end
      advance();
   endtask

   task automatic test_random();
      int q[$];
      logic [3:0] comp, r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         q.delete();
         for (int t = 1; t < 16; t++) if (m_tv[t]) q.push_back(t);
         comp = (q.size() > 0 && $urandom_range(0, 9) < 4) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'd0;
         r = 4'd0;
         if (m_slot_v && $urandom_range(0, 9) < 7) begin
            q.delete();
            for (int t = 1; t < 16; t++) if (!m_tv[t] || t == int'(comp)) q.push_back(t);
            r = 4'(q[$urandom_range(0, q.size() - 1)]);
         end else if (!m_slot_v && $urandom_range(0, 3) == 0) begin
            r = 4'($urandom_range(1, 15));
         end
         set_in($urandom_range(0, 9) < 6, {$urandom(), $urandom()}, $urandom_range(0, 9) < 6,
                {$urandom(), $urandom()}, {$urandom(), $urandom()}, r, comp, {$urandom(), $urandom()});
         checks++; if (bus.ld_req_ready !== e_ld_rdy || bus.st_req_ready !== e_st_rdy)
            begin fails++; $display("FAIL rnd_ready c%0d: ld %b st %b want %b %b", c, bus.ld_req_ready, bus.st_req_ready, e_ld_rdy, e_st_rdy); end
         checks++; if (bus.proc2mem_command !== exp_cmd() || bus.proc2mem_address !== m_slot_addr || bus.proc2mem_data !== m_slot_data)
            begin fails++; $display("FAIL rnd_bus c%0d: cmd %0d addr %h data %h want %0d %h %h", c, bus.proc2mem_command, bus.proc2mem_address, bus.proc2mem_data, exp_cmd(), m_slot_addr, m_slot_data); end
         checks++; if (bus.ld_rsp_valid !== m_ldrsp || bus.st_done !== m_stdone)
            begin fails++; $display("FAIL rnd_pulse c%0d: ld %b st %b want %b %b", c, bus.ld_rsp_valid, bus.st_done, m_ldrsp, m_stdone); end
         if (m_ldrsp) begin
            checks++; if (bus.ld_rsp_addr !== m_ldrsp_addr || bus.ld_rsp_data !== m_ldrsp_data)
               begin fails++; $display("FAIL rnd_rsp c%0d: addr %h data %h want %h %h", c, bus.ld_rsp_addr, bus.ld_rsp_data, m_ldrsp_addr, m_ldrsp_data); end
         end
         checks++; if (outstanding_count !== 5'(live()) || tag_err !== m_err)
            begin fails++; $display("FAIL rnd_state c%0d: count %0d err %b want %0d %b", c, outstanding_count, tag_err, live(), m_err); end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_starvation();
      test_max_outstanding();
      test_tag_reuse();
      test_unknown_tag();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
